// File: rtl/lab2_entry_conditioner.sv
// Input conditioner for the Lab2 combination lock.
// Synchronizes a raw push-button and a 4-bit switch bank.
// Debounces the button with a counter-based FSM.
// Emits one registered single-cycle Enter strobe per accepted press, with the
// switch value captured into Digit on the same edge.
//
// Optional build macro ENTRY_DIGIT_STABLE_EN: the switches are shadowed when
// qualification starts. Any change seen during qualification poisons the
// press, so it never strobes and Digit keeps its previous value.
module lab2_entry_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH       = 5
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ButtonRaw,
  input  logic [3:0] SwitchesRaw,
  output logic       Enter,
  output logic [3:0] Digit,
  output logic       Pressed
);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } state_e;

  // Count value on the last cycle of qualification.
  localparam logic [CNT_WIDTH-1:0] CntTerm = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

  // Synchronizer stages
  logic       btn_meta_q, btn_meta_d;
  logic       btn_sync_q, btn_sync_d;
  logic [3:0] sw_meta_q, sw_meta_d;
  logic [3:0] sw_sync_q, sw_sync_d;

  // Debounce FSM and registered outputs
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 enter_q, enter_d;
  logic [3:0]           digit_q, digit_d;
  logic                 pressed_q, pressed_d;

  logic       btn_s;
  logic [3:0] sw_s;
  logic       term_hit;
  logic       press_ok;

  assign btn_s = btn_sync_q;
  assign sw_s  = sw_sync_q;

`ifdef ENTRY_DIGIT_STABLE_EN
  logic [3:0] shadow_q, shadow_d;
  logic       poison_q, poison_d;
`endif

  // Synchronizer next-state: plain two-stage shift of the raw inputs.
  always_comb begin
    btn_meta_d = ButtonRaw;
    btn_sync_d = btn_meta_q;
    sw_meta_d  = SwitchesRaw;
    sw_sync_d  = sw_meta_q;
  end

  // Debounce FSM next-state, counter and output decode.
  always_comb begin
    state_d  = state_q;
    term_hit = 1'b0;

    case (state_q)
      StIdle: begin
        if (btn_s) state_d = StPressWait;
      end
      StPressWait: begin
        if (!btn_s) begin
          state_d = StIdle;
        end else if (cnt_q == CntTerm) begin
          state_d  = StHeld;
          term_hit = 1'b1;
        end
      end
      StHeld: begin
        if (!btn_s) state_d = StReleaseWait;
      end
      StReleaseWait: begin
        // A bounce back to 1 returns to HELD without a new strobe.
        if (btn_s) begin
          state_d = StHeld;
        end else if (cnt_q == CntTerm) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Every transition restarts qualification from zero.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == StPressWait || state_q == StReleaseWait) begin
      cnt_d = cnt_q + CntOne;
    end else begin
      cnt_d = cnt_q;
    end

`ifdef ENTRY_DIGIT_STABLE_EN
    shadow_d = shadow_q;
    poison_d = poison_q;
    if (state_q == StIdle && state_d == StPressWait) begin
      shadow_d = sw_s;
      poison_d = 1'b0;
    end else if (state_q == StPressWait && sw_s != shadow_q) begin
      poison_d = 1'b1;
    end
    // Include the terminal cycle itself, which poison_q has not yet seen.
    press_ok = !poison_q && (sw_s == shadow_q);
`else
    press_ok = 1'b1;
`endif

    enter_d = 1'b0;
    digit_d = digit_q;
    if (term_hit && press_ok) begin
      enter_d = 1'b1;
      digit_d = sw_s;
    end

    pressed_d = (state_d == StHeld) || (state_d == StReleaseWait);
  end

  // Synchronizer flops.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      sw_meta_q  <= 4'h0;
      sw_sync_q  <= 4'h0;
    end else begin
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
    end
  end

  // FSM state, debounce counter and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      enter_q   <= 1'b0;
      digit_q   <= 4'h0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      enter_q   <= enter_d;
      digit_q   <= digit_d;
      pressed_q <= pressed_d;
    end
  end

`ifdef ENTRY_DIGIT_STABLE_EN
  // Switch shadow and poison flag for the stable-digit option.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      shadow_q <= 4'h0;
      poison_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      poison_q <= poison_d;
    end
  end
`endif

  assign Enter   = enter_q;
  assign Digit   = digit_q;
  assign Pressed = pressed_q;

endmodule

// File: tb/tb_lab2_entry_conditioner.sv
// Directed bench for lab2_entry_conditioner with default parameters
// (DEBOUNCE_CYCLES = 16): 19 ticks from applying a stable press to Enter high.
module tb_lab2_entry_conditioner;

  logic       Clock;
  logic       Reset;
  logic       ButtonRaw;
  logic [3:0] SwitchesRaw;
  logic       Enter;
  logic [3:0] Digit;
  logic       Pressed;

  int n_cmp = 0;
  int n_err = 0;

  // Running totals kept by the monitor; the sequence snapshots them.
  int enter_total   = 0;
  int pressed_total = 0;
  int double_enter  = 0;
  logic enter_prev  = 1'b0;

  int e0;
  int p0;

  lab2_entry_conditioner dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .ButtonRaw   (ButtonRaw),
    .SwitchesRaw (SwitchesRaw),
    .Enter       (Enter),
    .Digit       (Digit),
    .Pressed     (Pressed)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Count strobes, back-to-back strobes and Pressed cycles away from the edge.
  always @(negedge Clock) begin
    if (Enter === 1'b1) enter_total <= enter_total + 1;
    if (Enter === 1'b1 && enter_prev === 1'b1) double_enter <= double_enter + 1;
    if (Pressed === 1'b1) pressed_total <= pressed_total + 1;
    enter_prev <= Enter;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset       = 1'b1;
    ButtonRaw   = 1'b0;
    SwitchesRaw = 4'h0;

    // Reset for 3 cycles, then idle for 100.
    tick(3);
    check("rst_enter", {31'b0, Enter}, 0);
    check("rst_digit", {28'b0, Digit}, 0);
    check("rst_pressed", {31'b0, Pressed}, 0);
    Reset = 1'b0;
    e0 = enter_total;
    p0 = pressed_total;
    tick(100);
    check("idle_enter_cnt", enter_total - e0, 0);
    check("idle_pressed_cnt", pressed_total - p0, 0);
    check("idle_digit", {28'b0, Digit}, 0);

    // Clean press held 40 cycles with switches = 2.
    SwitchesRaw = 4'h2;
    ButtonRaw   = 1'b1;
    e0 = enter_total;
    tick(18);
    check("clean_no_early_enter", enter_total - e0, 0);
    check("clean_not_pressed_yet", {31'b0, Pressed}, 0);
    tick(1);
    check("clean_enter_hi", {31'b0, Enter}, 1);
    check("clean_digit", {28'b0, Digit}, 2);
    check("clean_pressed_hi", {31'b0, Pressed}, 1);
    tick(1);
    check("clean_enter_lo", {31'b0, Enter}, 0);
    tick(20);
    check("clean_one_enter", enter_total - e0, 1);
    ButtonRaw = 1'b0;
    tick(18);
    check("release_pressed_still", {31'b0, Pressed}, 1);
    tick(1);
    check("release_pressed_lo", {31'b0, Pressed}, 0);
    check("release_no_enter", enter_total - e0, 1);
    check("release_digit_held", {28'b0, Digit}, 2);
    tick(10);

    // Button toggling every 5 cycles: never qualifies.
    e0 = enter_total;
    p0 = pressed_total;
    for (int i = 0; i < 6; i++) begin
      ButtonRaw = 1'b1;
      tick(5);
      ButtonRaw = 1'b0;
      tick(5);
    end
    tick(30);
    check("toggle_no_enter", enter_total - e0, 0);
    check("toggle_no_pressed", pressed_total - p0, 0);

    // Bouncy press then bouncy release, switches = 9.
    SwitchesRaw = 4'h9;
    e0 = enter_total;
    for (int i = 0; i < 3; i++) begin
      ButtonRaw = 1'b1;
      tick(4);
      ButtonRaw = 1'b0;
      tick(4);
    end
    check("bounce_press_rejected", enter_total - e0, 0);
    ButtonRaw = 1'b1;
    tick(18);
    check("bounce_no_early_enter", enter_total - e0, 0);
    tick(1);
    check("bounce_enter_hi", {31'b0, Enter}, 1);
    check("bounce_digit", {28'b0, Digit}, 9);
    tick(11);
    for (int i = 0; i < 2; i++) begin
      ButtonRaw = 1'b0;
      tick(4);
      ButtonRaw = 1'b1;
      tick(4);
    end
    check("bounce_release_still_pressed", {31'b0, Pressed}, 1);
    ButtonRaw = 1'b0;
    tick(30);
    check("bounce_one_enter", enter_total - e0, 1);
    check("bounce_released", {31'b0, Pressed}, 0);

    // Two presses entering 2 then 3.
    e0 = enter_total;
    SwitchesRaw = 4'h2;
    ButtonRaw   = 1'b1;
    tick(30);
    check("two_first_digit", {28'b0, Digit}, 2);
    check("two_first_cnt", enter_total - e0, 1);
    ButtonRaw = 1'b0;
    tick(30);
    SwitchesRaw = 4'h3;
    ButtonRaw   = 1'b1;
    tick(30);
    check("two_second_digit", {28'b0, Digit}, 3);
    check("two_second_cnt", enter_total - e0, 2);
    ButtonRaw = 1'b0;
    tick(30);

    // Reset pulsed mid-qualification with the button held, switches = 5.
    e0 = enter_total;
    SwitchesRaw = 4'h5;
    ButtonRaw   = 1'b1;
    tick(10);
    Reset = 1'b1;
    tick(1);
    check("midrst_no_enter", enter_total - e0, 0);
    check("midrst_digit_cleared", {28'b0, Digit}, 0);
    check("midrst_pressed_lo", {31'b0, Pressed}, 0);
    Reset = 1'b0;
    tick(18);
    check("midrst_no_early_enter", enter_total - e0, 0);
    tick(1);
    check("midrst_enter_hi", {31'b0, Enter}, 1);
    check("midrst_digit", {28'b0, Digit}, 5);
    ButtonRaw = 1'b0;
    tick(30);
    check("midrst_one_enter", enter_total - e0, 1);

    // Switches change from 6 to 7 partway through qualification.
    e0 = enter_total;
    SwitchesRaw = 4'h6;
    ButtonRaw   = 1'b1;
    tick(10);
    SwitchesRaw = 4'h7;
    tick(20);
    check("swchg_pressed", {31'b0, Pressed}, 1);
`ifdef ENTRY_DIGIT_STABLE_EN
    check("swchg_poisoned_no_enter", enter_total - e0, 0);
    check("swchg_digit_unchanged", {28'b0, Digit}, 5);
`else
    check("swchg_enter", enter_total - e0, 1);
    check("swchg_digit_late", {28'b0, Digit}, 7);
`endif
    ButtonRaw = 1'b0;
    tick(30);

    check("never_double_enter", double_enter, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
